// File: rtl/pingpong_replay_pkg.sv
// Shared types and config helpers for the ping-pong replay buffer.
// Both banks and the top FSM use these enums.
package pingpong_replay_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    typedef enum logic {
        EMPTY,
        FULL
    } bank_e;

    // Extracts a width-bit field starting at lsb from a packed config word.
    function automatic logic [31:0] cfg_field(
        input logic [63:0] cfg,
        input int          lsb,
        input int          width
    );
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return 32'((cfg >> lsb) & mask);
    endfunction

endpackage

// File: rtl/replay_bank_mem.sv
// One replay bank: synchronous write port, combinational read port.
// Contents are not reset; a bank is only read once marked FULL.
module replay_bank_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pingpong_replay_buf.sv
// Two-bank replay buffer: one bank fills while the other replays
// its block nPeriod times.
module pingpong_replay_buf #(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_nDATA   = 1024,
    parameter int MAX_nPERIOD = 524288,
    localparam int NDW        = $clog2(MAX_nDATA),
    localparam int NPW        = $clog2(MAX_nPERIOD),
    localparam int CFG_W      = NPW + NDW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [CFG_W-1:0]      config_bits,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_last,
    output logic                  busy,
    output logic                  done
);

    import pingpong_replay_pkg::*;

    state_e           state_q, state_d;
    bank_e            bank_q [2];
    bank_e            bank_d [2];
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [NDW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [NDW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [NPW-1:0]   per_cnt_q, per_cnt_d;
    logic [NDW-1:0]   ndm1_q, ndm1_d;
    logic [NPW-1:0]   npm1_q, npm1_d;
    logic             done_q, done_d;

    logic [DATA_WIDTH-1:0] rdata [2];
    logic wr_fire, rd_fire;
    logic wr_end, rd_end, per_end;
    logic any_full;

    assign w_ready  = (state_q == RUN) && (bank_q[wr_bank_q] == EMPTY);
    assign r_valid  = (bank_q[rd_bank_q] == FULL);
    assign wr_fire  = w_valid && w_ready;
    assign rd_fire  = r_valid && r_ready;
    assign wr_end   = (wr_cnt_q == ndm1_q);
    assign rd_end   = (rd_cnt_q == ndm1_q);
    assign per_end  = (per_cnt_q == npm1_q);
    assign any_full = (bank_q[0] == FULL) || (bank_q[1] == FULL);
    assign r_last   = r_valid && rd_end && per_end;
    assign r_data   = rdata[rd_bank_q];
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        per_cnt_d = per_cnt_q;
        ndm1_d    = ndm1_q;
        npm1_d    = npm1_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    ndm1_d    = NDW'(cfg_field(64'(config_bits), 0, NDW));
                    npm1_d    = NPW'(cfg_field(64'(config_bits), NDW, NPW));
                    wr_bank_d = 1'b0;
                    rd_bank_d = 1'b0;
                    wr_cnt_d  = '0;
                    rd_cnt_d  = '0;
                    per_cnt_d = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!any_full) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_fire) begin
            if (wr_end) begin
                wr_cnt_d          = '0;
                bank_d[wr_bank_q] = FULL;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end

        // A partially written bank is abandoned on stop and stays EMPTY.
        if ((state_q == RUN) && stop) begin
            wr_cnt_d = '0;
        end

        if (rd_fire) begin
            if (rd_end) begin
                rd_cnt_d = '0;
                if (per_end) begin
                    per_cnt_d         = '0;
                    bank_d[rd_bank_q] = EMPTY;
                    rd_bank_d         = ~rd_bank_q;
                end else begin
                    per_cnt_d = per_cnt_q + 1'b1;
                end
            end else begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bank_q[0] <= EMPTY;
            bank_q[1] <= EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            per_cnt_q <= '0;
            ndm1_q    <= '0;
            npm1_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            per_cnt_q <= per_cnt_d;
            ndm1_q    <= ndm1_d;
            npm1_q    <= npm1_d;
            done_q    <= done_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        replay_bank_mem #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (MAX_nDATA)
        ) u_mem (
            .clk  (clk),
            .we   (wr_fire && (wr_bank_q == 1'(b))),
            .waddr(wr_cnt_q),
            .wdata(w_data),
            .raddr(rd_cnt_q),
            .rdata(rdata[b])
        );
    end

endmodule

// File: tb/tb_pingpong_replay_buf.sv
// Bench for pingpong_replay_buf: block-level reference model plus
// scenario tasks for latency, back-to-back, stop and reset cases.
module tb_pingpong_replay_buf;

    localparam int DW    = 16;
    localparam int MAXD  = 8;
    localparam int MAXP  = 4;
    localparam int NDW   = $clog2(MAXD);
    localparam int NPW   = $clog2(MAXP);
    localparam int CFG_W = NDW + NPW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [CFG_W-1:0] config_bits = '0;
    logic             w_valid = 1'b0;
    logic             w_ready;
    logic [DW-1:0]    w_data = '0;
    logic             r_valid;
    logic             r_ready = 1'b0;
    logic [DW-1:0]    r_data;
    logic             r_last;
    logic             busy;
    logic             done;

    pingpong_replay_buf #(
        .DATA_WIDTH (DW),
        .MAX_nDATA  (MAXD),
        .MAX_nPERIOD(MAXP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .config_bits(config_bits),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_data     (r_data),
        .r_last     (r_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        bit            lst;
    } beat_t;

    int checks = 0;
    int failures = 0;

    // Reference model: run mode, accepted blocks expanded into beats.
    int            m_st = 0;
    int            m_nd = 1;
    int            m_np = 1;
    int            full_cnt = 0;
    bit            done_exp = 0;
    beat_t         exp_q [$];
    logic [DW-1:0] cur_q [$];

    int cyc = 0;
    int rd_count = 0;
    int wr_count = 0;
    int last_cnt = 0;
    int last_beat = 0;
    int last_rd_cyc = 0;
    int both_full = 0;
    int done_cnt = 0;
    bit w_fire_s = 0;
    bit r_fire_s = 0;

    logic [DW-1:0] wq [$];
    int wr_idx = 0;
    int w_duty = 100;
    int r_duty = 100;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (w_fire_s) wr_idx++;
            w_valid = (wr_idx < wq.size()) &&
                      ($urandom_range(99) < w_duty);
            w_data  = w_valid ? wq[wr_idx] : '0;
            r_ready = ($urandom_range(99) < r_duty);
        end
    end

    always @(negedge clk) begin : mon
        beat_t b;
        bit    e_wr;
        bit    e_rv;
        int    pre_st;
        cyc++;
        if (rst) begin
            m_st = 0;
            full_cnt = 0;
            done_exp = 0;
            exp_q.delete();
            cur_q.delete();
            w_fire_s = 0;
            r_fire_s = 0;
        end else begin
            e_wr = (m_st == 1) && (full_cnt < 2);
            e_rv = (full_cnt > 0);
            checks++;
            if (w_ready !== e_wr) begin
                failures++;
                $display("FAIL w_ready cyc=%0d got=%b exp=%b",
                         cyc, w_ready, e_wr);
            end
            checks++;
            if (r_valid !== e_rv) begin
                failures++;
                $display("FAIL r_valid cyc=%0d got=%b exp=%b",
                         cyc, r_valid, e_rv);
            end
            checks++;
            if (busy !== (m_st != 0)) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b exp=%b",
                         cyc, busy, (m_st != 0));
            end
            checks++;
            if (done !== done_exp) begin
                failures++;
                $display("FAIL done cyc=%0d got=%b exp=%b",
                         cyc, done, done_exp);
            end
            if (e_rv && exp_q.size() > 0) begin
                checks++;
                if (r_data !== exp_q[0].data) begin
                    failures++;
                    $display("FAIL r_data cyc=%0d got=%0d exp=%0d",
                             cyc, r_data, exp_q[0].data);
                end
                checks++;
                if (r_last !== exp_q[0].lst) begin
                    failures++;
                    $display("FAIL r_last cyc=%0d got=%b exp=%b",
                             cyc, r_last, exp_q[0].lst);
                end
            end
            if (full_cnt == 2) both_full++;
            if (done) done_cnt++;

            w_fire_s = w_valid && w_ready;
            r_fire_s = r_valid && r_ready;

            done_exp = 0;
            pre_st = m_st;
            case (m_st)
                0: if (start) begin
                    m_st = 1;
                    m_nd = int'(config_bits[NDW-1:0]) + 1;
                    m_np = int'(config_bits[CFG_W-1:NDW]) + 1;
                end
                1: if (stop) m_st = 2;
                default: if (full_cnt == 0) begin
                    m_st = 0;
                    done_exp = 1;
                end
            endcase

            if (w_fire_s) begin
                wr_count++;
                cur_q.push_back(w_data);
                if (cur_q.size() == m_nd) begin
                    for (int p = 0; p < m_np; p++) begin
                        for (int i = 0; i < m_nd; i++) begin
                            b.data = cur_q[i];
                            b.lst  = (p == m_np - 1) && (i == m_nd - 1);
                            exp_q.push_back(b);
                        end
                    end
                    full_cnt++;
                    cur_q.delete();
                end
            end
            if (pre_st == 1 && stop) cur_q.delete();

            if (r_fire_s && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                rd_count++;
                last_rd_cyc = cyc;
                if (b.lst) begin
                    last_cnt++;
                    last_beat = rd_count;
                    full_cnt--;
                end
            end
        end
    end

    task automatic wait_reads(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (rd_count >= n) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_writes(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (wr_count >= n) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic start_run(input int nd, input int np);
        @(posedge clk);
        #1;
        config_bits = CFG_W'(((np - 1) << NDW) | (nd - 1));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic end_run(output bit ok);
        @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        wait_idle(300, ok);
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (w_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_w_ready got=%b exp=0", w_ready);
        end
        checks++;
        if (r_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_r_valid got=%b exp=0", r_valid);
        end
        checks++;
        if (r_last !== 1'b0) begin
            failures++;
            $display("FAIL rst_r_last got=%b exp=0", r_last);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy got=%b exp=0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL rst_done got=%b exp=0", done);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int br = rd_count;
        int bw = wr_count;
        int bl = last_cnt;
        bit ok;
        w_duty = 100;
        r_duty = 100;
        start_run(4, 3);
        for (int i = 0; i < 4; i++) wq.push_back(DW'(i));
        wait_writes(bw + 4, 50, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL basic_wr_timeout got=%0d exp=%0d", wr_count, bw + 4);
        end
        #1;
        checks++;
        if (r_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_latency r_valid got=%b exp=1", r_valid);
        end
        wait_reads(br + 12, 100, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL basic_rd_timeout got=%0d exp=%0d", rd_count - br, 12);
        end
        checks++;
        if (last_cnt - bl !== 1) begin
            failures++;
            $display("FAIL basic_last_count got=%0d exp=1", last_cnt - bl);
        end
        checks++;
        if (last_beat !== br + 12) begin
            failures++;
            $display("FAIL basic_last_beat got=%0d exp=%0d", last_beat - br, 12);
        end
        end_run(ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL basic_drain got=busy exp=idle");
        end
    endtask

    task automatic test_back_to_back;
        int br = rd_count;
        int bw = wr_count;
        int c1;
        int rd_at;
        bit ok;
        w_duty = 100;
        r_duty = 100;
        start_run(4, 2);
        for (int i = 0; i < 4; i++) wq.push_back(DW'(10 + i));
        for (int i = 0; i < 4; i++) wq.push_back(DW'(20 + i));
        wait_reads(br + 1, 50, ok);
        c1 = last_rd_cyc;
        wait_writes(bw + 8, 50, ok);
        rd_at = rd_count - br;
        checks++;
        if (!(ok && rd_at < 8)) begin
            failures++;
            $display("FAIL b2b_fill reads_before_B_done got=%0d exp=<8", rd_at);
        end
        wait_reads(br + 16, 100, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL b2b_rd_timeout got=%0d exp=16", rd_count - br);
        end
        checks++;
        if (last_rd_cyc - c1 !== 15) begin
            failures++;
            $display("FAIL b2b_bubble span got=%0d exp=15", last_rd_cyc - c1);
        end
        end_run(ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL b2b_drain got=busy exp=idle");
        end
    endtask

    task automatic test_slow_reader;
        int br = rd_count;
        int bw = wr_count;
        int bf = both_full;
        bit ok;
        w_duty = 100;
        r_duty = 25;
        start_run(4, 2);
        for (int i = 0; i < 12; i++) wq.push_back(DW'($urandom));
        wait_reads(br + 24, 3000, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL slow_rd_timeout got=%0d exp=24", rd_count - br);
        end
        checks++;
        if (wr_count - bw !== 12) begin
            failures++;
            $display("FAIL slow_writes got=%0d exp=12", wr_count - bw);
        end
        checks++;
        if (both_full - bf <= 0) begin
            failures++;
            $display("FAIL slow_backpressure both_full_cycles got=%0d exp=>0",
                     both_full - bf);
        end
        r_duty = 100;
        end_run(ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL slow_drain got=busy exp=idle");
        end
    endtask

    task automatic test_unit_block;
        int br = rd_count;
        int bl = last_cnt;
        bit ok;
        w_duty = 70;
        r_duty = 60;
        start_run(1, 1);
        wq.push_back(DW'(7));
        wq.push_back(DW'(8));
        wq.push_back(DW'(9));
        wait_reads(br + 3, 300, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL unit_rd_timeout got=%0d exp=3", rd_count - br);
        end
        checks++;
        if (last_cnt - bl !== 3) begin
            failures++;
            $display("FAIL unit_last_count got=%0d exp=3", last_cnt - bl);
        end
        w_duty = 100;
        r_duty = 100;
        end_run(ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL unit_drain got=busy exp=idle");
        end
    endtask

    task automatic test_stop;
        int br = rd_count;
        int bw = wr_count;
        int bd = done_cnt;
        bit ok;
        w_duty = 100;
        r_duty = 100;
        start_run(4, 2);
        for (int i = 0; i < 6; i++) wq.push_back(DW'($urandom));
        wait_writes(bw + 6, 50, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL stop_wr_timeout got=%0d exp=6", wr_count - bw);
        end
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        wait_idle(200, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL stop_drain got=busy exp=idle");
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (rd_count - br !== 8) begin
            failures++;
            $display("FAIL stop_reads got=%0d exp=8", rd_count - br);
        end
        checks++;
        if (done_cnt - bd !== 1) begin
            failures++;
            $display("FAIL stop_done_pulses got=%0d exp=1", done_cnt - bd);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_async_reset;
        int br = rd_count;
        bit ok;
        w_duty = 100;
        r_duty = 100;
        start_run(4, 3);
        for (int i = 0; i < 4; i++) wq.push_back(DW'($urandom));
        wait_reads(br + 3, 100, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL arst_rd_timeout got=%0d exp=3", rd_count - br);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (r_valid !== 1'b0) begin
            failures++;
            $display("FAIL arst_r_valid got=%b exp=0", r_valid);
        end
        checks++;
        if (w_ready !== 1'b0) begin
            failures++;
            $display("FAIL arst_w_ready got=%b exp=0", w_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL arst_busy got=%b exp=0", busy);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        br = rd_count;
        start_run(2, 1);
        for (int i = 0; i < 4; i++) wq.push_back(DW'($urandom));
        wait_reads(br + 4, 100, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL arst_rerun got=%0d exp=4", rd_count - br);
        end
        end_run(ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL arst_drain got=busy exp=idle");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_slow_reader();
        test_unit_block();
        test_stop();
        test_async_reset();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
